// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared state encoding for the fifo write-port arbiter
package fifo_write_arbiter_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_arbiter_pick: combinational round-robin winner search starting just after last_grant
module rr_arbiter_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] winner
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);
  localparam logic [IDX_WIDTH:0] N_REQ = (IDX_WIDTH+1)'(NUM_REQ);
  logic [IDX_WIDTH:0] shift;
  logic [IDX_WIDTH:0] sum;
  logic [NUM_REQ-1:0] rotated;
  always_comb begin
    shift = {1'b0, last_grant} + (IDX_WIDTH+1)'(1);
    rotated = NUM_REQ'({req, req} >> shift);
    sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) sum = rotated[i] ? (IDX_WIDTH+1)'(i) : sum;
    sum = sum + shift;
    winner = sum >= N_REQ ? IDX_WIDTH'(sum - N_REQ) : IDX_WIDTH'(sum);
    any = |req;
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-locked sharing of one fifo write port with a registered output
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_o_valid,
  input  logic                          data_o_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          grant_busy_o
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);
  localparam int CNT_WIDTH = $clog2(MAX_BURST);
  arb_state_t state;
  logic [IDX_WIDTH-1:0] grant;
  logic [IDX_WIDTH-1:0] pick;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic any, port_open, in_xfer, out_xfer;
  rr_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid_i),
    .last_grant (grant),
    .any        (any),
    .winner     (pick)
  );
  // grant doubles as last_grant: in IDLE it always holds the most recent grantee
  assign port_open    = (state == LOCKED) && (!data_o_valid || data_o_ready);
  assign req_ready_o  = port_open ? NUM_REQ'(1) << grant : '0;
  assign in_xfer      = port_open && req_valid_i[grant];
  assign out_xfer     = data_o_valid && data_o_ready;
  assign grant_id_o   = grant;
  assign grant_busy_o = (state == LOCKED);
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state        <= IDLE;
      grant        <= IDX_WIDTH'(NUM_REQ - 1);
      burst_cnt    <= '0;
      data_o       <= '0;
      data_o_valid <= 1'b0;
    end else begin
      if (in_xfer) begin
        data_o       <= req_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        data_o_valid <= 1'b1;
      end else if (out_xfer) begin
        data_o_valid <= 1'b0;
      end
      if (state == IDLE) begin
        if (any) begin
          state     <= LOCKED;
          grant     <= pick;
          burst_cnt <= '0;
        end
      end else if (in_xfer) begin
        burst_cnt <= burst_cnt + CNT_WIDTH'(1);
        if (req_last_i[grant] || burst_cnt == CNT_WIDTH'(MAX_BURST - 1)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and randomized checks against a transaction-level arbitration model
module tb_fifo_write_arbiter;
  localparam int NR = 4, DW = 32, MB = 4, TR = 64, BUDGET = 2000;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0] req_valid_i = '0;
  logic [NR-1:0] req_last_i = '0;
  logic [NR-1:0] req_ready_o;
  logic [DW-1:0] data_o;
  logic data_o_valid;
  logic data_o_ready = 1'b0;
  logic [1:0] grant_id_o;
  logic grant_busy_o;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .data_o       (data_o),
    .data_o_valid (data_o_valid),
    .data_o_ready (data_o_ready),
    .grant_id_o   (grant_id_o),
    .grant_busy_o (grant_busy_o)
  );

  always #5 clk = ~clk;

  logic [DW:0] pq[NR][$];
  logic [DW-1:0] got[$];
  int grants[$];
  logic [NR-1:0] rdy_tr[TR];
  logic dv_tr[TR];
  logic busy_tr[TR];
  logic [DW-1:0] do_tr[TR];
  logic [1:0] gid_tr[TR];
  int t, bp, s0, s1, n_cmp, n_bad;
  logic busy_q;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got_v, exp_v, t);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] d, input logic last);
    pq[k].push_back({last, d});
  endtask

  task automatic load(input int k, input int n, input int last_pct);
    for (int i = 0; i < n; i++)
      push(k, DW'($urandom), (i == n - 1) || ($urandom_range(0, 99) < last_pct));
  endtask

  function automatic bit pending();
    for (int k = 0; k < NR; k++) if (pq[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid_i[k] = pq[k].size() != 0;
      {req_last_i[k], req_data_i[k*DW +: DW]} = pq[k].size() != 0 ? pq[k][0] : '0;
    end
    data_o_ready = !(t >= s0 && t < s1) && ($urandom_range(0, 99) >= bp);
  endtask

  task automatic tick();
    int fk;
    logic of;
    logic [DW-1:0] ob;
    @(negedge clk);
    if (t < TR) begin
      rdy_tr[t] = req_ready_o;
      dv_tr[t] = data_o_valid;
      busy_tr[t] = grant_busy_o;
      do_tr[t] = data_o;
      gid_tr[t] = grant_id_o;
    end
    check("ready_onehot0", 64'($onehot0(req_ready_o)), 1);
    if (grant_busy_o && !busy_q) grants.push_back(int'(grant_id_o));
    busy_q = grant_busy_o;
    fk = -1;
    for (int k = 0; k < NR; k++) if (req_valid_i[k] && req_ready_o[k]) fk = k;
    of = data_o_valid && data_o_ready;
    ob = data_o;
    @(posedge clk);
    #1;
    if (of) got.push_back(ob);
    if (fk >= 0) void'(pq[fk].pop_front());
    t++;
    drive();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    for (int k = 0; k < NR; k++) pq[k].delete();
    got.delete();
    grants.delete();
    req_valid_i = '0;
    req_last_i = '0;
    req_data_i = '0;
    data_o_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", req_ready_o, 0);
    check("rst_valid", data_o_valid, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", grant_busy_o, 0);
    check("rst_grant_id", grant_id_o, NR - 1);
    reset_i = 1'b0;
    busy_q = 1'b0;
    t = 0;
    s0 = 0;
    s1 = 0;
    bp = 0;
  endtask

  // Model: each free slot goes to the next producer (round-robin) with beats pending;
  // its burst runs to its last beat or MAX_BURST beats, whichever comes first.
  task automatic run(input int bp_i, input int s0_i, input int s1_i);
    logic [DW:0] mq[NR][$];
    logic [DW-1:0] expq[$];
    int expg[$];
    int lg, k, n, cyc;
    logic [DW:0] b;
    for (int i = 0; i < NR; i++) mq[i] = pq[i];
    lg = NR - 1;
    while (1) begin
      k = -1;
      for (int s = 1; s <= NR; s++) if (k < 0 && mq[(lg + s) % NR].size() != 0) k = (lg + s) % NR;
      if (k < 0) break;
      expg.push_back(k);
      n = 0;
      while (1) begin
        b = mq[k].pop_front();
        expq.push_back(b[DW-1:0]);
        n++;
        if (b[DW] || n == MB) break;
      end
      lg = k;
    end
    bp = bp_i;
    s0 = s0_i;
    s1 = s1_i;
    drive();
    cyc = 0;
    while ((pending() || got.size() < expq.size()) && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check("timeout", 64'(cyc < BUDGET), 1);
    repeat (3) tick();
    check("beat_count", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) check("beat_data", got[i], expq[i]);
    check("grant_count", grants.size(), expg.size());
    for (int i = 0; i < grants.size() && i < expg.size(); i++) check("grant_order", grants[i], expg[i]);
  endtask

  initial begin
    bit [5:0] exp_rdy;
    bit [5:0] exp_dv;
    bit [9:0] exp_busy2;
    bit [10:0] exp_busy3;
    int order[5];
    n_cmp = 0;
    n_bad = 0;
    t = 0;
    exp_rdy = 6'b001110;
    exp_dv = 6'b011100;
    exp_busy2 = 10'b1010101010;
    exp_busy3 = 11'b01111011110;
    order = '{0, 1, 2, 3, 0};

    do_reset();
    push(0, 32'hA0, 1'b0);
    push(0, 32'hA1, 1'b0);
    push(0, 32'hA2, 1'b1);
    run(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check("t1_ready0", rdy_tr[i][0], exp_rdy[i]);
      check("t1_valid", dv_tr[i], exp_dv[i]);
    end
    check("t1_grant_id", gid_tr[1], 0);

    do_reset();
    push(0, 32'hC0, 1'b1);
    push(0, 32'hC4, 1'b1);
    push(1, 32'hC1, 1'b1);
    push(2, 32'hC2, 1'b1);
    push(3, 32'hC3, 1'b1);
    run(0, 0, 0);
    for (int i = 0; i < 10; i++) check("t2_bubble", busy_tr[i], exp_busy2[i]);
    for (int i = 0; i < 5; i++) check("t2_order", grants.size() > i ? grants[i] : -1, order[i]);

    do_reset();
    for (int i = 0; i < 8; i++) push(2, DW'(32'hD0 + i), i == 7);
    run(0, 0, 0);
    for (int i = 0; i < 11; i++) check("t3_burst_lock", busy_tr[i], exp_busy3[i]);

    do_reset();
    push(1, 32'hB0, 1'b0);
    push(1, 32'hB1, 1'b0);
    push(1, 32'hB2, 1'b1);
    run(0, 2, 7);
    for (int i = 2; i < 7; i++) begin
      check("t4_hold_data", do_tr[i], 32'hB0);
      check("t4_ready_low", rdy_tr[i][1], 0);
    end
    check("t4_resume", rdy_tr[7][1], 1);

    do_reset();
    load(3, 4, 0);
    drive();
    repeat (3) tick();
    check("t5_mid_valid", data_o_valid, 1);
    check("t5_mid_busy", grant_busy_o, 1);
    do_reset();
    for (int k = 0; k < NR; k++) push(k, DW'(32'hE0 + k), 1'b1);
    run(0, 0, 0);
    check("t5_first_grant", grants.size() > 0 ? grants[0] : -1, 0);

    for (int r = 0; r < 25; r++) begin
      do_reset();
      for (int k = 0; k < NR; k++) load(k, $urandom_range(0, 10), 30);
      run($urandom_range(0, 60), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
